// File: rtl/muldiv_alu_seq.sv
// Time-shares the execute-stage ALU with iterative unsigned mul/div.
// Idle: pipeline drives the ALU; busy: 32 ADD/SUB steps, then done pulse.
`ifndef ALU_OPCODE_ADD
`define ALU_OPCODE_ADD 4'b0000
`endif
`ifndef ALU_OPCODE_SUB
`define ALU_OPCODE_SUB 4'b1000
`endif

module muldiv_alu_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mop,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] pipe_op1,
    input  logic [DATA_WIDTH-1:0] pipe_op2,
    input  logic [3:0]            pipe_ctrl,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    output logic [3:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic                  stall,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   result_q, result_d;

    logic           carry, ge;
    logic [W:0]     rs;
    logic [W-1:0]   step_acc, step_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // acc holds hi/rem, sh holds lo/quotient, opb holds multiplicand/divisor
    always_comb begin
        carry = alu_out < acc_q;
        rs    = {acc_q, sh_q[W-1]};
        ge    = rs[W] | (rs[W-1:0] >= opb_q);
        if (op_q[1]) begin
            step_acc = ge ? alu_out : rs[W-1:0];
            step_sh  = {sh_q[W-2:0], ge};
        end else begin
            step_acc = {carry, alu_out[W-1:1]};
            step_sh  = {alu_out[0], sh_q[W-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        alu_op1  = pipe_op1;
        alu_op2  = pipe_op2;
        alu_ctrl = pipe_ctrl;
        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    op_d  = mop;
                    acc_d = '0;
                    sh_d  = src_a;
                    opb_d = src_b;
                    cnt_d = '0;
                    if (mop[1] && src_b == '0) begin
                        state_d  = DONE;
                        result_d = mop[0] ? src_a : '1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (op_q[1]) begin
                    alu_op1  = rs[W-1:0];
                    alu_op2  = opb_q;
                    alu_ctrl = `ALU_OPCODE_SUB;
                end else begin
                    alu_op1  = acc_q;
                    alu_op2  = sh_q[0] ? opb_q : '0;
                    alu_ctrl = `ALU_OPCODE_ADD;
                end
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc;
                    sh_d  = step_sh;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) begin
                        state_d  = DONE;
                        // odd opcodes (MULHU/REMU) take the acc half
                        result_d = op_q[0] ? step_acc : step_sh;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign stall  = (state_q == IDLE && start && !flush) ||
                    (state_q == RUN);
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule
